// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side bundle between pipeline control and the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int REG_W  = 5,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
);
  localparam int FW = $clog2(STAGES + 1);

  logic             advance;
  logic             flush;
  logic             issue_valid;
  logic             issue_wen;
  logic [REG_W-1:0] issue_wsel;
  logic             issue_load;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             rs_used;
  logic             rt_used;
  logic             mem_req;
  logic             dhit;
  logic [FW-1:0]    fwd_rs;
  logic [FW-1:0]    fwd_rt;
  logic             stall;
  logic             freeze;
  logic             clr_cnt;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output advance, flush, issue_valid, issue_wen, issue_wsel, issue_load,
    output rs, rt, rs_used, rt_used, mem_req, dhit, clr_cnt,
    input  fwd_rs, fwd_rt, stall, freeze, stall_cycles
  );

  modport slave (
    input  advance, flush, issue_valid, issue_wen, issue_wsel, issue_load,
    input  rs, rt, rs_used, rt_used, mem_req, dhit, clr_cnt,
    output fwd_rs, fwd_rt, stall, freeze, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - STAGES-deep in-flight write scoreboard: forwarding, load-use stall, cache freeze
// Define HAZ_PERF_EN to build the stall/freeze cycle counter; otherwise stall_cycles reads 0.
module hazard_scoreboard #(
  parameter int REG_W      = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 1,
  parameter int CNT_W      = 16
) (
  input logic               CLK,
  input logic               RST,
  hazard_scoreboard_if.slave sb
);
  localparam int FW = $clog2(STAGES + 1);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t state, state_nxt;

  // index 0 is the youngest entry (EX), STAGES-1 is WB
  logic [STAGES-1:0]            e_valid;
  logic [STAGES-1:0]            e_wen;
  logic [STAGES-1:0]            e_load;
  logic [STAGES-1:0][REG_W-1:0] e_wsel;

  logic [FW-1:0] fwd_rs_c, fwd_rt_c;
  logic          hz_rs, hz_rt;
  logic          stall_c, freeze_c;

  // Walk oldest to youngest so the youngest forwardable match is left standing.
  always_comb begin
    fwd_rs_c = '0;
    fwd_rt_c = '0;
    hz_rs    = 1'b0;
    hz_rt    = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (e_valid[k] && e_wen[k] && e_wsel[k] != '0) begin
        if (e_load[k] && k < LOAD_STAGE) begin
          if (sb.rs_used && e_wsel[k] == sb.rs) hz_rs = 1'b1;
          if (sb.rt_used && e_wsel[k] == sb.rt) hz_rt = 1'b1;
        end else begin
          if (sb.rs_used && e_wsel[k] == sb.rs) fwd_rs_c = FW'(k + 1);
          if (sb.rt_used && e_wsel[k] == sb.rt) fwd_rt_c = FW'(k + 1);
        end
      end
    end
  end

  assign stall_c  = (state == RUN) && sb.issue_valid && (hz_rs || hz_rt);
  assign freeze_c = sb.mem_req && !sb.dhit;

  assign sb.fwd_rs = RST ? '0 : fwd_rs_c;
  assign sb.fwd_rt = RST ? '0 : fwd_rt_c;
  assign sb.stall  = !RST && stall_c;
  assign sb.freeze = !RST && freeze_c;

  always_comb begin
    state_nxt = state;
    if (freeze_c) begin
      state_nxt = MEM_WAIT;
    end else begin
      case (state)
        RUN:      if (stall_c && sb.advance) state_nxt = LU_STALL;
        LU_STALL: if (sb.advance) state_nxt = RUN;
        MEM_WAIT: state_nxt = RUN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= RUN;
      e_valid <= '0;
      e_wen   <= '0;
      e_load  <= '0;
      e_wsel  <= '0;
    end else begin
      state <= state_nxt;
      if (!freeze_c && sb.advance) begin
        // a stall re-presents the decode instruction, so a flush alongside it is moot
        e_valid <= {e_valid[STAGES-2:0], !stall_c && sb.issue_valid && !sb.flush};
        e_wen   <= {e_wen[STAGES-2:0],   sb.issue_wen};
        e_load  <= {e_load[STAGES-2:0],  sb.issue_load};
        e_wsel  <= {e_wsel[STAGES-2:0],  sb.issue_wsel};
      end
    end
  end

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (sb.clr_cnt) begin
      cnt <= '0;
    end else if ((stall_c || freeze_c) && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sb.stall_cycles = cnt;
`else
  logic unused_clr_cnt;

  assign unused_clr_cnt  = sb.clr_cnt;
  assign sb.stall_cycles = '0;
`endif
endmodule
